axi_line_ctl: RTL and testbench
===============================

Name: axi_line_ctl

Overview:
- AXI4 master that services 64-byte cache-line transfers for dcache/icache.
- Responder side of the cache-to-axi_ctl fifo handshake.
- Collects eight 64-bit write-back beats from the cache and issues an INCR burst write, or issues an INCR burst read and holds the refilled line for the cache to index.
- Sits between the L1 caches and the SoC AXI interconnect.

Parameters:
- ADDR_W, 64, address width
- DATA_W, 64, beat width in bits
- BEATS, 8, beats per line (line = BEATS*DATA_W/8 bytes)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous and active-low (rst==0 resets on the clk rising edge)
- axi_req  in  1  line request from cache
- axi_rw  in  1  0=read/refill, 1=write-back
- axi_req_addr  in  64  line address; bits [5:0] ignored
- axi_fifo_wen  in  1  push one write beat
- axi_fifo_data_i  in  64  write beat data
- axi_fifo_idx  in  9  refill bit index; beat select = idx[8:6]
- axi_fifo_done  in  1  cache releases the completed transaction
- axi_ready  out  1  idle and able to accept a request
- axi_done  out  1  transaction complete; refill data valid
- axi_data_o  out  64  refill beat selected by axi_fifo_idx[8:6]
- awvalid/awready/awaddr[63:0]/awlen[7:0]/awsize[2:0]/awburst[1:0]  AXI AW channel
- wvalid/wready/wdata[63:0]/wstrb[7:0]/wlast  AXI W channel
- bvalid/bready/bresp[1:0]  AXI B channel
- arvalid/arready/araddr[63:0]/arlen[7:0]/arsize[2:0]/arburst[1:0]  AXI AR channel
- rvalid/rready/rdata[63:0]/rresp[1:0]/rlast  AXI R channel

Behaviour:
- Reset: all valids, bready, rready, axi_done = 0; axi_ready = 1; state IDLE; wr_cnt, beat counters = 0. Line buffer contents are not reset.
- Constants: awlen/arlen = BEATS-1 (7), size = 3'b011, burst = INCR (2'b01), wstrb = 8'hFF. Addresses are {axi_req_addr[63:6],6'b0}, latched on accept.
- Write fifo:
  - axi_fifo_wen writes buf[wr_cnt] and increments wr_cnt (4 bits).
  - Pushes when wr_cnt==BEATS are dropped.
  - Pushes are accepted in any state except READ refill (AR/R).
- State machine (IDLE, AW, W, B, AR, R, DONE):
  - IDLE: axi_ready = 1. On axi_req, latch address and rw. Go to AW if rw=1, else AR. Request is accepted 1 cycle after assertion.
  - AW: awvalid = 1, held stable until awready; then go to W.
  - W:
    - wvalid = 1 only while beat < wr_cnt, so the W channel stalls if the cache has not yet pushed that beat.
    - wdata = buf[beat]; wlast = (beat == BEATS-1); beat advances on wvalid & wready.
    - After the last beat, go to B.
  - B: bready = 1. On bvalid, go to DONE.
  - AR: arvalid = 1 held until arready; beat = 0; then go to R.
  - R:
    - rready = 1. On rvalid, buf[beat] <= rdata and beat++.
    - After BEATS beats go to DONE. Termination is by count; rlast is not used for control.
  - DONE:
    - axi_done = 1 and axi_data_o = buf[axi_fifo_idx[8:6]] (combinational).
    - On axi_fifo_done==1 or axi_req==0: wr_cnt <= 0, then IDLE the next cycle.
- One outstanding transaction. AW precedes W; no AW/W overlap.
- Reset asserted mid-burst: abandon immediately, drop all valids, go to IDLE. The burst is not completed on AXI; the system resets the interconnect too.
- Simultaneous axi_fifo_done and new axi_req in DONE: release first. The new request is accepted in IDLE.

Optional Feature:
- AXI_RESP_CHECK_EN
  - Defined: adds output axi_err (1 bit, reset 0). Set in DONE if any rresp/bresp of the transaction was non-zero, or if rlast disagreed with beat==BEATS-1. Cleared on release.
  - Undefined: port absent; responses ignored.

Decomposition:
- Package axi_line_pkg:
  - state enum
  - AXI_BURST_INCR, AXI_SIZE_8B, AXI_RESP_OKAY
  - LINE_BEATS
- Sub-module line_buf: BEATS x DATA_W register file, one write port (mux of fifo push and R beat), two async read ports (W beat, cache index).

Test Plan:
- Refill: req rw=0 addr 0x8000_1234 → araddr 0x8000_1200, arlen 7. Eight rdata 0x11..0x88 with rvalid every cycle → axi_done=1; idx=0 gives 0x11, idx=448 gives 0x88.
- Write-back: push 8 beats 0xA0..0xA7, req rw=1 addr 0x8000_2040 → awaddr 0x8000_2040; wdata sequence 0xA0..0xA7, wlast on the 8th beat; done after bvalid.
- W starvation: req rw=1 after only 3 pushes → wvalid drops after beat 2; resumes the cycle after the 4th push.
- Backpressure: awready/arready low for 5 cycles, wready toggling → awaddr/araddr stable while valid; no beat lost or duplicated.
- Reset mid-R at beat 4 (rst=0 for 1 cycle) → all valids 0, axi_ready=1 next cycle; a new refill completes correctly.
- With AXI_RESP_CHECK_EN: rresp=2'b10 on beat 3 → axi_err=1 in DONE; cleared after axi_fifo_done.

Source files
------------

// File: rtl/axi_line_pkg.sv
// Shared types and AXI constants for the cache-line AXI master (axi_line_ctl).
package axi_line_pkg;

  localparam int unsigned LINE_BEATS     = 8;
  localparam logic [1:0]  AXI_BURST_INCR = 2'b01;
  localparam logic [2:0]  AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0]  AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AW,
    ST_W,
    ST_B,
    ST_AR,
    ST_R,
    ST_DONE
  } state_e;

endpackage

// File: rtl/axi_line_ctl_if.sv
// AXI4 five-channel bundle used by axi_line_ctl (master) and its interconnect (slave).
interface axi_line_ctl_if #(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64
);

  logic              awvalid, awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid, wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic       bvalid, bready;
  logic [1:0] bresp;

  logic              arvalid, arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid, rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bresp, output bready,
    output arvalid, araddr, arlen, arsize, arburst, input arready,
    input  rvalid, rdata, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bresp, input bready,
    input  arvalid, araddr, arlen, arsize, arburst, output arready,
    output rvalid, rdata, rresp, rlast, input rready
  );

endinterface

// File: rtl/axi_line_ctl_line_buf.sv
// Line buffer: BEATS x DATA_W registers, one write port, two async read ports.
module line_buf #(
  parameter int unsigned BEATS  = 8,
  parameter int unsigned DATA_W = 64,
  localparam int unsigned IDX_W = $clog2(BEATS)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  output logic [DATA_W-1:0] rdata_a_o,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] mem_q [BEATS];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = mem_q[raddr_a_i];
  assign rdata_b_o = mem_q[raddr_b_i];

endmodule

// File: rtl/axi_line_ctl.sv
// Cache-line AXI4 master: 8-beat INCR write-back or refill per request.
// Optional `AXI_RESP_CHECK_EN adds axi_err (bad resp / rlast misplacement).
module axi_line_ctl
  import axi_line_pkg::*;
#(
  parameter int unsigned ADDR_W = 64,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned BEATS  = LINE_BEATS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axi_req,
  input  logic              axi_rw,
  input  logic [ADDR_W-1:0] axi_req_addr,
  input  logic              axi_fifo_wen,
  input  logic [DATA_W-1:0] axi_fifo_data_i,
  input  logic [8:0]        axi_fifo_idx,
  input  logic              axi_fifo_done,
  output logic              axi_ready,
  output logic              axi_done,
  output logic [DATA_W-1:0] axi_data_o,
  axi_line_ctl_if.master    axi
`ifdef AXI_RESP_CHECK_EN
  ,
  output logic              axi_err
`endif
);

  localparam int unsigned IDX_W  = $clog2(BEATS);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned OFF_W  = $clog2(BEATS * DATA_W / 8);
  localparam int unsigned SEL_LO = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BEATS);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              buf_we;
  logic [IDX_W-1:0]  buf_waddr;
  logic [DATA_W-1:0] buf_wdata, buf_wbeat;
  logic              push_ok, w_fire;
`ifdef AXI_RESP_CHECK_EN
  logic              err_q, err_d;
`endif

  line_buf #(.BEATS(BEATS), .DATA_W(DATA_W)) u_buf (
    .clk       (clk),
    .we_i      (buf_we),
    .waddr_i   (buf_waddr),
    .wdata_i   (buf_wdata),
    .raddr_a_i (beat_q[IDX_W-1:0]),
    .rdata_a_o (buf_wbeat),
    .raddr_b_i (axi_fifo_idx[SEL_LO +: IDX_W]),
    .rdata_b_o (axi_data_o)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wr_cnt_q <= '0;
      beat_q   <= '0;
`ifdef AXI_RESP_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wr_cnt_q <= wr_cnt_d;
      beat_q   <= beat_d;
`ifdef AXI_RESP_CHECK_EN
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    wr_cnt_d    = wr_cnt_q;
    beat_d      = beat_q;
    axi_ready   = 1'b0;
    axi_done    = 1'b0;
    axi.awvalid = 1'b0;
    axi.wvalid  = 1'b0;
    axi.bready  = 1'b0;
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
    w_fire      = 1'b0;
`ifdef AXI_RESP_CHECK_EN
    err_d       = err_q;
`endif
    // Cache pushes share the single write port; refill owns it during AR/R.
    push_ok   = axi_fifo_wen && (wr_cnt_q != FULL) &&
                (state_q != ST_AR) && (state_q != ST_R);
    buf_we    = push_ok;
    buf_waddr = wr_cnt_q[IDX_W-1:0];
    buf_wdata = axi_fifo_data_i;
    if (push_ok) wr_cnt_d = wr_cnt_q + 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        axi_ready = 1'b1;
        if (axi_req) begin
          addr_d  = {axi_req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          beat_d  = '0;
          state_d = axi_rw ? ST_AW : ST_AR;
        end
      end
      ST_AW: begin
        axi.awvalid = 1'b1;
        if (axi.awready) state_d = ST_W;
      end
      ST_W: begin
        axi.wvalid = (beat_q < wr_cnt_q);
        w_fire     = axi.wvalid && axi.wready;
        if (w_fire) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == LAST) state_d = ST_B;
        end
      end
      ST_B: begin
        axi.bready = 1'b1;
        if (axi.bvalid) begin
          state_d = ST_DONE;
`ifdef AXI_RESP_CHECK_EN
          if (axi.bresp != AXI_RESP_OKAY) err_d = 1'b1;
`endif
        end
      end
      ST_AR: begin
        axi.arvalid = 1'b1;
        if (axi.arready) state_d = ST_R;
      end
      ST_R: begin
        axi.rready = 1'b1;
        if (axi.rvalid) begin
          buf_we    = 1'b1;
          buf_waddr = beat_q[IDX_W-1:0];
          buf_wdata = axi.rdata;
          beat_d    = beat_q + 1'b1;
          if (beat_q == LAST) state_d = ST_DONE;
`ifdef AXI_RESP_CHECK_EN
          if ((axi.rresp != AXI_RESP_OKAY) || (axi.rlast != (beat_q == LAST))) err_d = 1'b1;
`endif
        end
      end
      ST_DONE: begin
        axi_done = 1'b1;
        if (axi_fifo_done || !axi_req) begin
          buf_we   = 1'b0;
          wr_cnt_d = '0;
          state_d  = ST_IDLE;
`ifdef AXI_RESP_CHECK_EN
          err_d    = 1'b0;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign axi.awaddr  = addr_q;
  assign axi.awlen   = 8'(BEATS - 1);
  assign axi.awsize  = AXI_SIZE_8B;
  assign axi.awburst = AXI_BURST_INCR;
  assign axi.wdata   = buf_wbeat;
  assign axi.wstrb   = '1;
  assign axi.wlast   = (beat_q == LAST);
  assign axi.araddr  = addr_q;
  assign axi.arlen   = 8'(BEATS - 1);
  assign axi.arsize  = AXI_SIZE_8B;
  assign axi.arburst = AXI_BURST_INCR;

`ifdef AXI_RESP_CHECK_EN
  assign axi_err = (state_q == ST_DONE) && err_q;
  logic unused_in;
  assign unused_in = ^{axi_req_addr[OFF_W-1:0], axi_fifo_idx[SEL_LO-1:0]};
`else
  logic unused_in;
  assign unused_in = ^{axi_req_addr[OFF_W-1:0], axi_fifo_idx[SEL_LO-1:0],
                       axi.bresp, axi.rresp, axi.rlast};
`endif

endmodule

// File: tb/tb_axi_line_ctl.sv
// Self-checking bench for axi_line_ctl: directed table, hand sequences, random transactions.
module tb_axi_line_ctl;
  import axi_line_pkg::*;

  logic        clk = 1'b0;
  logic        rst, axi_req, axi_rw, axi_fifo_wen, axi_fifo_done;
  logic [63:0] axi_req_addr, axi_fifo_data_i, axi_data_o;
  logic [8:0]  axi_fifo_idx;
  logic        axi_ready, axi_done;
`ifdef AXI_RESP_CHECK_EN
  logic        axi_err;
`endif

  always #5 clk = ~clk;

  axi_line_ctl_if #(.ADDR_W(64), .DATA_W(64)) axi ();

  axi_line_ctl #(.ADDR_W(64), .DATA_W(64), .BEATS(8)) dut (
    .clk             (clk),
    .rst             (rst),
    .axi_req         (axi_req),
    .axi_rw          (axi_rw),
    .axi_req_addr    (axi_req_addr),
    .axi_fifo_wen    (axi_fifo_wen),
    .axi_fifo_data_i (axi_fifo_data_i),
    .axi_fifo_idx    (axi_fifo_idx),
    .axi_fifo_done   (axi_fifo_done),
    .axi_ready       (axi_ready),
    .axi_done        (axi_done),
    .axi_data_o      (axi_data_o),
    .axi             (axi)
`ifdef AXI_RESP_CHECK_EN
    ,
    .axi_err         (axi_err)
`endif
  );

  typedef struct {
    logic        rw;
    logic [63:0] addr;
    logic [63:0] exp_addr;
    int          pre_push;
    int          push_gap;
    int          addr_lat;
    int          rdy_mode;
    logic [63:0] base;
    logic [63:0] step;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [63:0] line_d [8];
  int          err_beat = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic rdy(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 2) == 0;
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_line(input logic [63:0] base, input logic [63:0] step);
    for (int i = 0; i < 8; i++) line_d[i] = base + 64'(i) * step;
  endtask

  task automatic run_txn(input vec_t v);
    int   pushed, beat, rcnt, cyc, gap;
    logic aw_done, ar_done, b_done, fin, push;
    logic e_awv, e_arv, e_wv, e_br, e_rr, e_done;
    logic aw_hs, ar_hs, w_hs, b_hs, r_hs, exp_err;
    pushed = 0; beat = 0; rcnt = 0; cyc = 0; gap = 0;
    aw_done = 0; ar_done = 0; b_done = 0; fin = 0;
    for (int i = 0; i < v.pre_push; i++) begin
      axi_fifo_wen    = 1'b1;
      axi_fifo_data_i = (i < 8) ? line_d[i] : 64'hDEAD_BEEF_0BAD_F00D;
      @(negedge clk);
      chk("idle_ready", axi_ready, 1'b1);
      tick();
      if (pushed < 8) pushed++;
    end
    axi_fifo_wen = 1'b0;
    axi_req = 1'b1; axi_rw = v.rw; axi_req_addr = v.addr;
    while (!fin && cyc < 400) begin
      axi.awready = (cyc >= v.addr_lat);
      axi.arready = (cyc >= v.addr_lat);
      axi.wready  = rdy(v.rdy_mode, cyc);
      axi.bvalid  = v.rw && beat == 8 && !b_done && rdy(v.rdy_mode, cyc + 1);
      axi.bresp   = 2'b00;
      axi.rvalid  = !v.rw && ar_done && rcnt < 8 && rdy(v.rdy_mode, cyc + 1);
      axi.rdata   = line_d[(rcnt < 8) ? rcnt : 0];
      axi.rlast   = (rcnt == 7);
      axi.rresp   = (rcnt == err_beat) ? 2'b10 : 2'b00;
      push = 1'b0;
      if (v.rw && pushed < 8) begin
        if (gap >= v.push_gap) begin push = 1'b1; gap = 0; end
        else gap++;
      end
      axi_fifo_wen    = push;
      axi_fifo_data_i = line_d[(pushed < 8) ? pushed : 0];
      @(negedge clk);
      e_awv  = v.rw && cyc >= 1 && !aw_done;
      e_arv  = !v.rw && cyc >= 1 && !ar_done;
      e_wv   = v.rw && aw_done && beat < 8 && beat < pushed;
      e_br   = v.rw && beat == 8 && !b_done;
      e_rr   = !v.rw && ar_done && rcnt < 8;
      e_done = v.rw ? b_done : (rcnt == 8);
      chk("axi_ready", axi_ready, cyc == 0);
      chk("awvalid", axi.awvalid, e_awv);
      chk("arvalid", axi.arvalid, e_arv);
      chk("wvalid", axi.wvalid, e_wv);
      chk("bready", axi.bready, e_br);
      chk("rready", axi.rready, e_rr);
      chk("axi_done", axi_done, e_done);
      if (e_awv) begin
        chk("awaddr", axi.awaddr, v.exp_addr);
        chk("awlen", axi.awlen, 8'd7);
        chk("awsize_burst", {axi.awsize, axi.awburst}, {3'b011, 2'b01});
      end
      if (e_arv) begin
        chk("araddr", axi.araddr, v.exp_addr);
        chk("arlen", axi.arlen, 8'd7);
        chk("arsize_burst", {axi.arsize, axi.arburst}, {3'b011, 2'b01});
      end
      if (e_wv) begin
        chk($sformatf("wdata[%0d]", beat), axi.wdata, line_d[beat]);
        chk("wlast", axi.wlast, beat == 7);
        chk("wstrb", axi.wstrb, 8'hFF);
      end
      aw_hs = e_awv && axi.awready;
      ar_hs = e_arv && axi.arready;
      w_hs  = e_wv && axi.wready;
      b_hs  = e_br && axi.bvalid;
      r_hs  = e_rr && axi.rvalid;
      if (e_done) fin = 1'b1;
      tick();
      if (push) pushed++;
      if (aw_hs) aw_done = 1'b1;
      if (ar_hs) ar_done = 1'b1;
      if (w_hs)  beat++;
      if (b_hs)  b_done = 1'b1;
      if (r_hs)  rcnt++;
      cyc++;
    end
    axi_fifo_wen = 1'b0; axi.bvalid = 1'b0; axi.rvalid = 1'b0;
    if (!fin) chk("txn_timeout", 1'b0, 1'b1);
    exp_err = !v.rw && err_beat >= 0;
    for (int i = 0; i < 8; i++) begin
      axi_fifo_idx = {3'(i), 6'($urandom)};
      @(negedge clk);
      chk($sformatf("data_o[%0d]", i), axi_data_o, line_d[i]);
      chk("done_hold", axi_done, 1'b1);
`ifdef AXI_RESP_CHECK_EN
      chk("axi_err", axi_err, exp_err);
`endif
      tick();
    end
    // Release with the request still high: release must win, no re-accept in DONE.
    axi_fifo_done = 1'b1;
    tick();
    axi_fifo_done = 1'b0; axi_req = 1'b0;
    @(negedge clk);
    chk("rel_ready", axi_ready, 1'b1);
    chk("rel_done", axi_done, 1'b0);
`ifdef AXI_RESP_CHECK_EN
    chk("rel_err", axi_err, 1'b0);
`endif
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got hang expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [6];
    vec_t rv;
    int   beats, cyc;
    logic hs;

    tbl[0] = '{1'b0, 64'h0000_0000_8000_1234, 64'h0000_0000_8000_1200, 0, 0, 0, 0, 64'h11, 64'h11};
    tbl[1] = '{1'b1, 64'h0000_0000_8000_2040, 64'h0000_0000_8000_2040, 8, 0, 0, 0, 64'hA0, 64'h1};
    tbl[2] = '{1'b1, 64'h0000_0000_8000_3000, 64'h0000_0000_8000_3000, 3, 6, 0, 0, 64'hB0, 64'h1};
    tbl[3] = '{1'b1, 64'h0000_0001_0000_0079, 64'h0000_0001_0000_0040, 8, 0, 6, 1, 64'hC0, 64'h3};
    tbl[4] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFC0, 0, 0, 6, 1, 64'h1234_5678_0000_0000, 64'h1111};
    tbl[5] = '{1'b1, 64'h0000_0000_0000_003F, 64'h0000_0000_0000_0000, 9, 0, 2, 2, 64'h5A5A_0000_0000_0001, 64'h7};

    rst = 1'b0; axi_req = 1'b0; axi_rw = 1'b0; axi_req_addr = '0;
    axi_fifo_wen = 1'b0; axi_fifo_data_i = '0; axi_fifo_idx = '0; axi_fifo_done = 1'b0;
    axi.awready = 1'b0; axi.wready = 1'b0; axi.bvalid = 1'b0; axi.bresp = 2'b00;
    axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rdata = '0; axi.rresp = 2'b00; axi.rlast = 1'b0;
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_ready", axi_ready, 1'b1);
    chk("rst_done", axi_done, 1'b0);
    chk("rst_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    tick();

    for (int t = 0; t < 6; t++) begin
      fill_line(tbl[t].base, tbl[t].step);
      run_txn(tbl[t]);
    end

    // Reset while four refill beats have landed: everything idles next cycle.
    fill_line(64'h77, 64'h101);
    axi_req = 1'b1; axi_rw = 1'b0; axi_req_addr = 64'h4000_0080; axi.arready = 1'b1;
    beats = 0; cyc = 0;
    while (beats < 4 && cyc < 50) begin
      axi.rvalid = 1'b1; axi.rdata = line_d[beats]; axi.rlast = 1'b0; axi.rresp = 2'b00;
      @(negedge clk);
      hs = axi.rready;
      tick();
      if (hs) beats++;
      cyc++;
    end
    if (beats < 4) chk("rst_seq_timeout", 1'b0, 1'b1);
    rst = 1'b0; axi_req = 1'b0; axi.rvalid = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    chk("midR_ready", axi_ready, 1'b1);
    chk("midR_done", axi_done, 1'b0);
    chk("midR_valids", {axi.awvalid, axi.wvalid, axi.arvalid, axi.bready, axi.rready}, 5'b0);
    tick();
    fill_line(64'hFACE_0000, 64'h10);
    rv = '{1'b0, 64'h4000_00BF, 64'h4000_0080, 0, 0, 1, 0, 64'h0, 64'h0};
    run_txn(rv);

`ifdef AXI_RESP_CHECK_EN
    err_beat = 3;
    fill_line(64'h11, 64'h11);
    rv = '{1'b0, 64'h8000_1234, 64'h8000_1200, 0, 0, 0, 0, 64'h0, 64'h0};
    run_txn(rv);
    err_beat = -1;
`endif

    for (int t = 0; t < 24; t++) begin
      rv.rw       = 1'($urandom_range(0, 1));
      rv.addr     = {$urandom, $urandom};
      rv.exp_addr = rv.addr & ~64'h3F;
      rv.pre_push = rv.rw ? int'($urandom_range(0, 8)) : 0;
      rv.push_gap = int'($urandom_range(0, 3));
      rv.addr_lat = int'($urandom_range(0, 4));
      rv.rdy_mode = 2;
      for (int i = 0; i < 8; i++) line_d[i] = {$urandom, $urandom};
      run_txn(rv);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
